sample_seq_ctrl: RTL and testbench

SAMPLE_SEQ_CTRL -- requirements
Module: sample_seq_ctrl

---
 rtl/sample_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sample_seq_ctrl.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_seq_ctrl.sv
// Multi-segment acquisition sequencer: steps a sampling core through consecutive
// address windows, with range checking, per-segment timeout and abort handling.
module sample_seq_ctrl #(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int SEG_WIDTH     = 16,
    parameter int TMO_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         run,
    input  logic                         abort,
    input  logic [MM_ADDR_WIDTH-1:0]     cfg_base_addr,
    input  logic [MM_ADDR_WIDTH-1:0]     cfg_seg_span,
    input  logic [MM_ADDR_WIDTH-1:0]     cfg_limit_addr,
    input  logic [31:0]                  cfg_sample_num,
    input  logic [31:0]                  cfg_pre_sample_num,
    input  logic [SEG_WIDTH-1:0]         cfg_seg_num,
    input  logic [TMO_WIDTH-1:0]         cfg_timeout,
    output logic [MM_ADDR_WIDTH-1:0]     config_start_addr,
    output logic [MM_ADDR_WIDTH-1:0]     config_end_addr,
    output logic [31:0]                  config_sample_num,
    output logic [31:0]                  config_pre_sample_num,
    output logic                         update_config,
    output logic                         sample_start,
    input  logic                         sample_busy,
    input  logic                         sample_done,
    input  logic                         sample_err,
    input  logic                         pkt_info_wr,
    input  logic [2*MM_ADDR_WIDTH-1:0]   pkt_info_data,
    output logic                         busy,
    output logic                         seq_done,
    output logic [1:0]                   err_code,
    output logic [SEG_WIDTH-1:0]         seg_idx,
    output logic [2*MM_ADDR_WIDTH-1:0]   last_pkt_info
);

    localparam int AW = MM_ADDR_WIDTH;
    localparam int XW = MM_ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT, S_FINISH
    } state_t;

    state_t                 state;
    logic [AW-1:0]          cur_start;
    logic [AW-1:0]          span_q;
    logic [AW-1:0]          limit_q;
    logic [31:0]            smp_q;
    logic [31:0]            pre_q;
    logic [SEG_WIDTH-1:0]   seg_eff;
    logic [TMO_WIDTH-1:0]   tmo_q;
    logic [TMO_WIDTH-1:0]   tmo_cnt;

    logic [XW-1:0]          chk_start;
    logic [XW-1:0]          chk_end;
    logic [SEG_WIDTH:0]     seg_next;
    logic                   range_bad;
    logic                   last_seg;
    logic                   tmo_hit;

    // Two extra bits keep start+span-1 exact, so a wrap past the address space
    // simply compares greater than the limit.
    always_comb begin
        chk_start = {2'b00, cur_start};
        if (state == S_NEXT)
            chk_start = chk_start + {2'b00, span_q};
        chk_end   = chk_start + {2'b00, span_q} - XW'(1);
        range_bad = chk_end > {2'b00, limit_q};
        seg_next  = {1'b0, seg_idx} + (SEG_WIDTH+1)'(1);
        last_seg  = seg_next >= {1'b0, seg_eff};
        tmo_hit   = (tmo_q != '0) && (tmo_cnt == TMO_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                 <= S_IDLE;
            busy                  <= 1'b0;
            update_config         <= 1'b0;
            sample_start          <= 1'b0;
            seq_done              <= 1'b0;
            err_code              <= '0;
            seg_idx               <= '0;
            config_start_addr     <= '0;
            config_end_addr       <= '0;
            config_sample_num     <= '0;
            config_pre_sample_num <= '0;
            last_pkt_info         <= '0;
            cur_start             <= '0;
            span_q                <= '0;
            limit_q               <= '0;
            smp_q                 <= '0;
            pre_q                 <= '0;
            seg_eff               <= '0;
            tmo_q                 <= '0;
            tmo_cnt               <= '0;
        end else begin
            update_config <= 1'b0;
            sample_start  <= 1'b0;
            seq_done      <= 1'b0;
            if (pkt_info_wr)
                last_pkt_info <= pkt_info_data;

            if (abort && state != S_IDLE) begin
                err_code <= 2'd3;
                // Already reporting completion: just record the abort and retire.
                if (state == S_FINISH) begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end else begin
                    seq_done <= 1'b1;
                    state    <= S_FINISH;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            cur_start <= cfg_base_addr;
                            span_q    <= cfg_seg_span;
                            limit_q   <= cfg_limit_addr;
                            smp_q     <= cfg_sample_num;
                            pre_q     <= cfg_pre_sample_num;
                            seg_eff   <= (cfg_seg_num == '0) ? SEG_WIDTH'(1) : cfg_seg_num;
                            tmo_q     <= cfg_timeout;
                            seg_idx   <= '0;
                            err_code  <= '0;
                            busy      <= 1'b1;
                            state     <= S_CFG;
                        end
                    end
                    // NEXT performs the CFG step for the following segment itself so
                    // that sample_done to update_config stays at two cycles.
                    S_CFG, S_NEXT: begin
                        if (state == S_NEXT && last_seg) begin
                            seq_done <= 1'b1;
                            state    <= S_FINISH;
                        end else begin
                            if (state == S_NEXT) begin
                                seg_idx   <= seg_next[SEG_WIDTH-1:0];
                                cur_start <= chk_start[AW-1:0];
                            end
                            if (range_bad) begin
                                err_code <= 2'd3;
                                seq_done <= 1'b1;
                                state    <= S_FINISH;
                            end else begin
                                config_start_addr     <= chk_start[AW-1:0];
                                config_end_addr       <= chk_end[AW-1:0];
                                config_sample_num     <= smp_q;
                                config_pre_sample_num <= pre_q;
                                update_config         <= 1'b1;
                                state                 <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        sample_start <= 1'b1;
                        tmo_cnt      <= tmo_q;
                        state        <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY, S_WAIT_DONE: begin
                        if (tmo_q != '0)
                            tmo_cnt <= tmo_cnt - TMO_WIDTH'(1);
                        if (sample_err) begin
                            err_code <= 2'd1;
                            seq_done <= 1'b1;
                            state    <= S_FINISH;
                        end else if (sample_done) begin
                            state <= S_NEXT;
                        end else if (tmo_hit) begin
                            err_code <= 2'd2;
                            seq_done <= 1'b1;
                            state    <= S_FINISH;
                        end else if (state == S_WAIT_BUSY && sample_busy) begin
                            state <= S_WAIT_DONE;
                        end
                    end
                    S_FINISH: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_seq_ctrl.sv
// Randomized self-checking bench for sample_seq_ctrl with a behavioural core model
// and an address-window reference model.
module tb_sample_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [31:0] cfg_seg_span = '0;
    logic [31:0] cfg_limit_addr = '0;
    logic [31:0] cfg_sample_num = '0;
    logic [31:0] cfg_pre_sample_num = '0;
    logic [15:0] cfg_seg_num = '0;
    logic [31:0] cfg_timeout = '0;
    logic [31:0] config_start_addr, config_end_addr, config_sample_num, config_pre_sample_num;
    logic        update_config, sample_start;
    logic        sample_busy, sample_done, sample_err;
    logic        pkt_info_wr = 1'b0;
    logic [63:0] pkt_info_data = '0;
    logic        busy, seq_done;
    logic [1:0]  err_code;
    logic [15:0] seg_idx;
    logic [63:0] last_pkt_info;

    sample_seq_ctrl #(.MM_ADDR_WIDTH(32), .SEG_WIDTH(16), .TMO_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .run(run), .abort(abort),
        .cfg_base_addr(cfg_base_addr), .cfg_seg_span(cfg_seg_span),
        .cfg_limit_addr(cfg_limit_addr), .cfg_sample_num(cfg_sample_num),
        .cfg_pre_sample_num(cfg_pre_sample_num), .cfg_seg_num(cfg_seg_num),
        .cfg_timeout(cfg_timeout),
        .config_start_addr(config_start_addr), .config_end_addr(config_end_addr),
        .config_sample_num(config_sample_num), .config_pre_sample_num(config_pre_sample_num),
        .update_config(update_config), .sample_start(sample_start),
        .sample_busy(sample_busy), .sample_done(sample_done), .sample_err(sample_err),
        .pkt_info_wr(pkt_info_wr), .pkt_info_data(pkt_info_data),
        .busy(busy), .seq_done(seq_done), .err_code(err_code),
        .seg_idx(seg_idx), .last_pkt_info(last_pkt_info)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int run_cyc = 0;

    // Event log of DUT strobes, sampled mid-cycle.
    logic [31:0] upd_start_q[$];
    logic [31:0] upd_end_q[$];
    logic [63:0] upd_num_q[$];
    int          upd_cyc_q[$];
    int          ss_cyc_q[$];
    int          sd_cyc_q[$];
    int          done_cyc_q[$];

    always @(negedge clk) begin
        if (update_config) begin
            upd_start_q.push_back(config_start_addr);
            upd_end_q.push_back(config_end_addr);
            upd_num_q.push_back({config_sample_num, config_pre_sample_num});
            upd_cyc_q.push_back(cyc);
        end
        if (sample_start) ss_cyc_q.push_back(cyc);
        if (seq_done)     sd_cyc_q.push_back(cyc);
    end

    // Core model: 0 = responds with done/err core_lat cycles after sample_start, 1 = silent.
    int          core_mode = 0;
    int          core_lat = 10;
    int          err_seg = -1;
    bit          core_busy_en = 1'b1;
    int          core_cnt = 0;
    bit          core_active = 1'b0;
    logic [15:0] core_seg = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            core_active = 1'b0;
            sample_busy = 1'b0;
            sample_done = 1'b0;
            sample_err  = 1'b0;
        end else begin
            sample_done = 1'b0;
            sample_err  = 1'b0;
            if (core_active) begin
                core_cnt = core_cnt - 1;
                if (core_cnt <= 0) begin
                    core_active = 1'b0;
                    sample_busy = 1'b0;
                    if (int'(core_seg) == err_seg) sample_err = 1'b1;
                    else begin
                        sample_done = 1'b1;
                        done_cyc_q.push_back(cyc);
                    end
                end
            end
            if (sample_start && core_mode == 0) begin
                core_active = 1'b1;
                core_cnt    = core_lat;
                core_seg    = seg_idx;
                sample_busy = core_busy_en;
            end
        end
    end

    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        run_cyc = cyc;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_seq_done(input int sd0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sd_cyc_q.size() > sd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, update_config, sample_start, seq_done, err_code, seg_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%b upd=%b ss=%b done=%b err=%0d idx=%0d, required all 0",
                     busy, update_config, sample_start, seq_done, err_code, seg_idx);
        end
        n_checks++;
        if ({config_start_addr, config_end_addr, config_sample_num, config_pre_sample_num, last_pkt_info} !== '0) begin
            n_fail++;
            $display("FAIL reset_config: got start=%h end=%h smp=%h pre=%h pkt=%h, required all 0",
                     config_start_addr, config_end_addr, config_sample_num, config_pre_sample_num, last_pkt_info);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Runs one acquisition and checks it against a window-by-window model of the sequence.
    task automatic test_sequence(input string name, input logic [31:0] base, input logic [31:0] span,
                                 input logic [31:0] limit, input logic [15:0] nseg, input logic [31:0] tmo,
                                 input int err_at, input int lat, input bit busy_en);
        logic [31:0] exp_s[$];
        logic [63:0] s64, e64;
        logic [31:0] smp, pre;
        int exp_err, exp_idx, eff, u0, s0, d0, dn0, nu, ns, nd;
        bit ok;
        exp_err = 0;
        exp_idx = 0;
        eff = (nseg == 16'd0) ? 1 : int'(nseg);
        for (int k = 0; k < eff; k++) begin
            exp_idx = k;
            s64 = {32'h0, base} + 64'(k) * {32'h0, span};
            e64 = s64 + {32'h0, span} - 64'd1;
            if (e64 > {32'h0, limit}) begin
                exp_err = 3;
                break;
            end
            exp_s.push_back(s64[31:0]);
            if (k == err_at) begin
                exp_err = 1;
                break;
            end
        end
        smp = $urandom;
        pre = $urandom;
        cfg_base_addr = base; cfg_seg_span = span; cfg_limit_addr = limit;
        cfg_sample_num = smp; cfg_pre_sample_num = pre; cfg_seg_num = nseg; cfg_timeout = tmo;
        core_mode = 0; core_lat = lat; err_seg = err_at; core_busy_en = busy_en;
        u0 = upd_start_q.size(); s0 = ss_cyc_q.size(); d0 = sd_cyc_q.size(); dn0 = done_cyc_q.size();
        pulse_run();
        wait_seq_done(d0, 2000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s seq_done_wait: got no seq_done within 2000 cycles, required one", name);
        end
        repeat (4) @(negedge clk);
        #1;
        nu = upd_start_q.size() - u0;
        ns = ss_cyc_q.size() - s0;
        nd = sd_cyc_q.size() - d0;
        n_checks++;
        if (nu != exp_s.size()) begin
            n_fail++;
            $display("FAIL %s update_count: got %0d required %0d", name, nu, exp_s.size());
        end
        n_checks++;
        if (ns != exp_s.size()) begin
            n_fail++;
            $display("FAIL %s start_count: got %0d required %0d", name, ns, exp_s.size());
        end
        n_checks++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL %s seq_done_count: got %0d required 1", name, nd);
        end
        n_checks++;
        if (err_code !== 2'(exp_err)) begin
            n_fail++;
            $display("FAIL %s err_code: got %0d required %0d", name, err_code, exp_err);
        end
        n_checks++;
        if (seg_idx !== 16'(exp_idx)) begin
            n_fail++;
            $display("FAIL %s seg_idx: got %0d required %0d", name, seg_idx, exp_idx);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after: got %b required 0", name, busy);
        end
        if (nu > 0) begin
            n_checks++;
            if (upd_cyc_q[u0] - run_cyc != 2) begin
                n_fail++;
                $display("FAIL %s run_latency: got %0d required 2", name, upd_cyc_q[u0] - run_cyc);
            end
        end
        for (int i = 0; i < nu && i < exp_s.size(); i++) begin
            n_checks++;
            if (upd_start_q[u0+i] !== exp_s[i] || upd_end_q[u0+i] !== exp_s[i] + span - 32'd1) begin
                n_fail++;
                $display("FAIL %s window[%0d]: got %h..%h required %h..%h", name, i,
                         upd_start_q[u0+i], upd_end_q[u0+i], exp_s[i], exp_s[i] + span - 32'd1);
            end
            n_checks++;
            if (upd_num_q[u0+i] !== {smp, pre}) begin
                n_fail++;
                $display("FAIL %s sample_nums[%0d]: got %h required %h", name, i, upd_num_q[u0+i], {smp, pre});
            end
            n_checks++;
            if (ss_cyc_q[s0+i] - upd_cyc_q[u0+i] != 1) begin
                n_fail++;
                $display("FAIL %s start_latency[%0d]: got %0d required 1", name, i, ss_cyc_q[s0+i] - upd_cyc_q[u0+i]);
            end
            if (i > 0) begin
                n_checks++;
                if (upd_cyc_q[u0+i] - done_cyc_q[dn0+i-1] != 2) begin
                    n_fail++;
                    $display("FAIL %s done_latency[%0d]: got %0d required 2", name, i,
                             upd_cyc_q[u0+i] - done_cyc_q[dn0+i-1]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int sd0, ss0, d;
        bit ok;
        core_mode = 1;
        cfg_base_addr = 32'h0000_1000; cfg_seg_span = 32'h100; cfg_limit_addr = 32'hFFFF_FFFF;
        cfg_seg_num = 16'd2; cfg_timeout = 32'd50;
        sd0 = sd_cyc_q.size(); ss0 = ss_cyc_q.size();
        pulse_run();
        wait_seq_done(sd0, 300, ok);
        n_checks++;
        if (!ok || err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL timeout_err: got done=%b err=%0d required done=1 err=2", ok, err_code);
        end
        d = sd_cyc_q[sd0] - ss_cyc_q[ss0];
        n_checks++;
        if (d < 49 || d > 51) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles required 50 +/-1", d);
        end
        n_checks++;
        if (ss_cyc_q.size() - ss0 != 1) begin
            n_fail++;
            $display("FAIL timeout_starts: got %0d required 1", ss_cyc_q.size() - ss0);
        end
        cfg_timeout = 32'd0;
        sd0 = sd_cyc_q.size();
        pulse_run();
        repeat (200) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || sd_cyc_q.size() != sd0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: got busy=%b dones=%0d required busy=1 dones=0", busy, sd_cyc_q.size() - sd0);
        end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        wait_seq_done(sd0, 20, ok);
        n_checks++;
        if (!ok || err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL abort_wait_err: got done=%b err=%0d required done=1 err=3", ok, err_code);
        end
        core_mode = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int sd0, ss0, u0;
        bit found;
        sd0 = sd_cyc_q.size();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || err_code !== 2'd0 || sd_cyc_q.size() != sd0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b err=%0d dones=%0d required 0/0/0", busy, err_code, sd_cyc_q.size() - sd0);
        end
        cfg_base_addr = 32'h2000_0000; cfg_seg_span = 32'h1000; cfg_limit_addr = 32'hFFFF_FFFF;
        cfg_seg_num = 16'd3; cfg_timeout = 32'd0;
        core_mode = 0; core_lat = 8; err_seg = -1; core_busy_en = 1'b1;
        sd0 = sd_cyc_q.size(); ss0 = ss_cyc_q.size(); u0 = upd_start_q.size();
        pulse_run();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (sample_done) begin
                found = 1'b1;
                break;
            end
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_done_wait: got no sample_done, required one");
        end
        n_checks++;
        if (err_code !== 2'd3 || seg_idx !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_done_err: got err=%0d idx=%0d required err=3 idx=0", err_code, seg_idx);
        end
        n_checks++;
        if (upd_start_q.size() - u0 != 1 || ss_cyc_q.size() - ss0 != 1 || sd_cyc_q.size() - sd0 != 1) begin
            n_fail++;
            $display("FAIL abort_done_counts: got upd=%0d ss=%0d done=%0d required 1/1/1",
                     upd_start_q.size() - u0, ss_cyc_q.size() - ss0, sd_cyc_q.size() - sd0);
        end
    endtask

    task automatic test_run_while_busy();
        int sd0, u0;
        bit ok;
        cfg_base_addr = 32'h4000_0000; cfg_seg_span = 32'h400; cfg_limit_addr = 32'hFFFF_FFFF;
        cfg_seg_num = 16'd2; cfg_timeout = 32'd0;
        core_mode = 0; core_lat = 12; err_seg = -1; core_busy_en = 1'b1;
        sd0 = sd_cyc_q.size(); u0 = upd_start_q.size();
        pulse_run();
        repeat (6) @(negedge clk);
        cfg_base_addr = 32'h5000_0000;
        cfg_seg_num = 16'd7;
        pulse_run();
        wait_seq_done(sd0, 200, ok);
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (!ok || upd_start_q.size() - u0 != 2 || sd_cyc_q.size() - sd0 != 1 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL run_busy_counts: got done=%b upd=%0d dones=%0d err=%0d required 1/2/1/0",
                     ok, upd_start_q.size() - u0, sd_cyc_q.size() - sd0, err_code);
        end
        n_checks++;
        if (upd_start_q[u0] !== 32'h4000_0000 || upd_start_q[u0+1] !== 32'h4000_0400) begin
            n_fail++;
            $display("FAIL run_busy_addrs: got %h,%h required 40000000,40000400", upd_start_q[u0], upd_start_q[u0+1]);
        end
    endtask

    task automatic test_pkt_info();
        logic [63:0] exp;
        exp = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        pkt_info_data = exp;
        pkt_info_wr = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (last_pkt_info !== exp) begin
            n_fail++;
            $display("FAIL pkt_info_load: got %h required %h", last_pkt_info, exp);
        end
        @(negedge clk);
        pkt_info_wr = 1'b0;
        pkt_info_data = {$urandom, $urandom};
        @(posedge clk);
        #1;
        n_checks++;
        if (last_pkt_info !== exp) begin
            n_fail++;
            $display("FAIL pkt_info_hold: got %h required %h", last_pkt_info, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = {$urandom, $urandom};
            pkt_info_data = exp;
            pkt_info_wr = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (last_pkt_info !== exp) begin
                n_fail++;
                $display("FAIL pkt_info_rand[%0d]: got %h required %h", i, last_pkt_info, exp);
            end
        end
        @(negedge clk);
        pkt_info_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int u0, s0;
        bit found;
        cfg_base_addr = 32'h6000_0000; cfg_seg_span = 32'h800; cfg_limit_addr = 32'hFFFF_FFFF;
        cfg_seg_num = 16'd3; cfg_timeout = 32'd0;
        core_mode = 0; core_lat = 30; err_seg = -1; core_busy_en = 1'b1;
        pulse_run();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (sample_busy) begin
                found = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (!found || {busy, update_config, sample_start, seq_done, err_code, seg_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_status: got found=%b busy=%b upd=%b ss=%b done=%b err=%0d idx=%0d required 1 and all 0",
                     found, busy, update_config, sample_start, seq_done, err_code, seg_idx);
        end
        n_checks++;
        if ({config_start_addr, config_end_addr, config_sample_num, config_pre_sample_num, last_pkt_info} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_config: got start=%h end=%h pkt=%h required all 0",
                     config_start_addr, config_end_addr, last_pkt_info);
        end
        u0 = upd_start_q.size(); s0 = ss_cyc_q.size();
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || upd_start_q.size() != u0 || ss_cyc_q.size() != s0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got busy=%b upd=%0d ss=%0d required 0/0/0",
                     busy, upd_start_q.size() - u0, ss_cyc_q.size() - s0);
        end
    endtask

    task automatic test_random();
        logic [31:0] base, span, limit, tmo;
        logic [63:0] lim64;
        int es, lat;
        bit be;
        for (int it = 0; it < 8; it++) begin
            base = $urandom & 32'hFFFF_FF00;
            if (it == 0) base = 32'hFFFF_F000;
            span = 32'($urandom_range(1, 2048));
            lim64 = {32'h0, base} + 64'($urandom_range(0, 6 * 2048));
            limit = (lim64 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : lim64[31:0];
            es = int'($urandom_range(0, 7));
            lat = int'($urandom_range(3, 12));
            be = 1'($urandom_range(0, 1));
            tmo = ($urandom_range(0, 1) == 1) ? 32'd500 : 32'd0;
            test_sequence($sformatf("random%0d", it), base, span, limit, 16'($urandom_range(0, 5)),
                          tmo, (es < 5) ? es : -1, lat, be);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequence("multi_segment", 32'hC000_0000, 32'h8000, 32'hC001_FFFF, 16'd4, 32'd0, -1, 20, 1'b1);
        test_sequence("range_fail", 32'hC000_0000, 32'h8000, 32'hC001_FFFF, 16'd5, 32'd0, -1, 20, 1'b1);
        test_sequence("core_err", 32'h1000_0000, 32'h200, 32'hFFFF_FFFF, 16'd3, 32'd0, 1, 10, 1'b1);
        test_sequence("addr_overflow", 32'hFFFF_0000, 32'h8000, 32'hFFFF_FFFF, 16'd3, 32'd0, -1, 6, 1'b0);
        test_sequence("seg_zero", 32'h0000_4000, 32'h100, 32'hFFFF_FFFF, 16'd0, 32'd0, -1, 5, 1'b1);
        test_abort();
        test_timeout();
        test_run_while_busy();
        test_pkt_info();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
